// File: rtl/lfsr_checker.sv
// Receive-side PRBS checker: self-synchronises to an 8-bit LFSR stream, then flags and counts mismatches.
// Optional build macro LFSR_CHECKER_ZERO_DET_EN adds sticky o_zero_lock and treats 8'h00 samples as illegal.
module lfsr_checker #(
  parameter logic [7:0] TAPS       = 8'hB8,
  parameter int         LOCK_CNT   = 4,
  parameter int         UNLOCK_CNT = 3,
  parameter int         ERR_W      = 16
) (
  input  logic             clk,
  input  logic             i_rst,
  input  logic             i_soft_reset,
  input  logic             i_valid,
  input  logic [7:0]       i_lfsr,
  input  logic             i_clr_err,
  output logic             o_lock,
  output logic             o_error,
  output logic [ERR_W-1:0] o_err_count,
  output logic [7:0]       o_expected
`ifdef LFSR_CHECKER_ZERO_DET_EN
  ,
  output logic             o_zero_lock
`endif
);

  // state    | meaning
  // UNLOCKED | predictor reloaded from every sample, counting consecutive correct predictions
  // LOCKED   | predictor free-runs, mismatches are flagged and counted
  typedef enum logic {UNLOCKED = 1'b0, LOCKED = 1'b1} state_t;

  localparam logic [3:0] LOCK_LAST   = 4'(LOCK_CNT - 1);
  localparam logic [3:0] UNLOCK_LAST = 4'(UNLOCK_CNT - 1);

  state_t           state_q, state_d;
  logic             have_prev_q, have_prev_d;
  logic [3:0]       match_cnt_q, match_cnt_d;
  logic [3:0]       miss_cnt_q, miss_cnt_d;
  logic             error_q, error_d;
  logic [ERR_W-1:0] err_cnt_q, err_cnt_d;
  logic [7:0]       exp_q, exp_d;
  logic             zero_lock_q, zero_lock_d;
  logic             zero_smp;
  logic             mismatch;

  function automatic logic [7:0] lfsr_next(input logic [7:0] x);
    return {x[6:0], ^(x & TAPS)};
  endfunction

`ifdef LFSR_CHECKER_ZERO_DET_EN
  assign zero_smp = (i_lfsr == 8'h00);
`else
  assign zero_smp = 1'b0;
`endif

  assign mismatch = (i_lfsr != exp_q) || zero_smp;

  always_comb begin
    state_d     = state_q;
    have_prev_d = have_prev_q;
    match_cnt_d = match_cnt_q;
    miss_cnt_d  = miss_cnt_q;
    error_d     = 1'b0;
    err_cnt_d   = err_cnt_q;
    exp_d       = exp_q;
    zero_lock_d = zero_lock_q;

    if (i_soft_reset) begin
      state_d     = UNLOCKED;
      have_prev_d = 1'b0;
      match_cnt_d = '0;
      miss_cnt_d  = '0;
      err_cnt_d   = '0;
      exp_d       = 8'h00;
      zero_lock_d = 1'b0;
    end else begin
      if (i_valid) begin
        if (zero_smp) zero_lock_d = 1'b1;
        case (state_q)
          UNLOCKED: begin
            if (zero_smp) begin
              match_cnt_d = '0;
              have_prev_d = 1'b0;
            end else if (!have_prev_q) begin
              have_prev_d = 1'b1;
              exp_d       = lfsr_next(i_lfsr);
            end else begin
              exp_d = lfsr_next(i_lfsr);
              if (i_lfsr == exp_q) begin
                if (match_cnt_q == LOCK_LAST) begin
                  state_d     = LOCKED;
                  match_cnt_d = '0;
                  miss_cnt_d  = '0;
                end else begin
                  match_cnt_d = match_cnt_q + 4'd1;
                end
              end else begin
                match_cnt_d = '0;
              end
            end
          end
          LOCKED: begin
            exp_d = lfsr_next(exp_q);
            if (mismatch) begin
              error_d = 1'b1;
              if (err_cnt_q != '1) err_cnt_d = err_cnt_q + 1'b1;
              if (miss_cnt_q == UNLOCK_LAST) begin
                state_d     = UNLOCKED;
                miss_cnt_d  = '0;
                match_cnt_d = '0;
                have_prev_d = 1'b0;
              end else begin
                miss_cnt_d = miss_cnt_q + 4'd1;
              end
            end else begin
              miss_cnt_d = '0;
            end
          end
          default: state_d = UNLOCKED;
        endcase
      end
      // clear beats a same-cycle increment; the error pulse is unaffected
      if (i_clr_err) err_cnt_d = '0;
    end
  end

  always_ff @(posedge clk or negedge i_rst) begin
    if (!i_rst) begin
      state_q     <= UNLOCKED;
      have_prev_q <= 1'b0;
      match_cnt_q <= '0;
      miss_cnt_q  <= '0;
      error_q     <= 1'b0;
      err_cnt_q   <= '0;
      exp_q       <= 8'h00;
      zero_lock_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      have_prev_q <= have_prev_d;
      match_cnt_q <= match_cnt_d;
      miss_cnt_q  <= miss_cnt_d;
      error_q     <= error_d;
      err_cnt_q   <= err_cnt_d;
      exp_q       <= exp_d;
      zero_lock_q <= zero_lock_d;
    end
  end

  assign o_lock      = (state_q == LOCKED);
  assign o_error     = error_q;
  assign o_err_count = err_cnt_q;
  assign o_expected  = exp_q;

`ifdef LFSR_CHECKER_ZERO_DET_EN
  assign o_zero_lock = zero_lock_q;
`else
  logic unused_zero;
  assign unused_zero = zero_lock_q;
`endif

endmodule

// File: tb/tb_lfsr_checker.sv
// Bench for lfsr_checker: two instances (default config, and ERR_W=4/UNLOCK_CNT=15) checked against a behavioural model.
module tb_lfsr_checker;

  logic       clk = 1'b0;
  logic       i_rst = 1'b0;
  logic       i_soft_reset = 1'b0;
  logic       i_valid = 1'b0;
  logic [7:0] i_lfsr = 8'h00;
  logic       i_clr_err = 1'b0;

  logic        lock_a, error_a, lock_b, error_b;
  logic [15:0] cnt_a;
  logic [3:0]  cnt_b;
  logic [7:0]  exp_a, exp_b;
`ifdef LFSR_CHECKER_ZERO_DET_EN
  logic zl_a, zl_b;
`endif

  always #5 clk = ~clk;

  lfsr_checker dut_a (
    .clk(clk), .i_rst(i_rst), .i_soft_reset(i_soft_reset), .i_valid(i_valid),
    .i_lfsr(i_lfsr), .i_clr_err(i_clr_err), .o_lock(lock_a), .o_error(error_a),
    .o_err_count(cnt_a), .o_expected(exp_a)
`ifdef LFSR_CHECKER_ZERO_DET_EN
    , .o_zero_lock(zl_a)
`endif
  );

  lfsr_checker #(.LOCK_CNT(4), .UNLOCK_CNT(15), .ERR_W(4)) dut_b (
    .clk(clk), .i_rst(i_rst), .i_soft_reset(i_soft_reset), .i_valid(i_valid),
    .i_lfsr(i_lfsr), .i_clr_err(i_clr_err), .o_lock(lock_b), .o_error(error_b),
    .o_err_count(cnt_b), .o_expected(exp_b)
`ifdef LFSR_CHECKER_ZERO_DET_EN
    , .o_zero_lock(zl_b)
`endif
  );

  int n_vec = 0;
  int n_bad = 0;

  task automatic check(input string name, input int act, input int req);
    n_vec++;
    if (act != req) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, req, $time);
    end
  endtask

  // Polynomial x^8+x^6+x^5+x^4+1 as a left shift with feedback from bits 7,5,4,3.
  function automatic logic [7:0] nxt(input logic [7:0] x);
    return {x[6:0], x[7] ^ x[5] ^ x[4] ^ x[3]};
  endfunction

  // Model, index 0 = dut_a, 1 = dut_b.
  int         unl[2]  = '{3, 15};
  int         cmax[2] = '{65535, 15};
  int         m_lock[2], m_have[2], m_match[2], m_miss[2], m_err[2], m_cnt[2];
  logic [7:0] m_exp[2];

  always @(posedge clk or negedge i_rst) begin
    for (int c = 0; c < 2; c++) begin
      if (!i_rst || i_soft_reset) begin
        m_lock[c] = 0; m_have[c] = 0; m_match[c] = 0; m_miss[c] = 0;
        m_err[c] = 0; m_cnt[c] = 0; m_exp[c] = 8'h00;
      end else begin
        m_err[c] = 0;
        if (i_valid) begin
          if (m_lock[c] == 0) begin
            if (m_have[c] == 0) m_have[c] = 1;
            else if (i_lfsr == m_exp[c]) m_match[c]++;
            else m_match[c] = 0;
            m_exp[c] = nxt(i_lfsr);
            if (m_match[c] == 4) begin m_lock[c] = 1; m_miss[c] = 0; end
          end else begin
            if (i_lfsr != m_exp[c]) begin
              m_err[c] = 1;
              m_cnt[c] = (m_cnt[c] + 1 > cmax[c]) ? cmax[c] : m_cnt[c] + 1;
              m_miss[c]++;
            end else begin
              m_miss[c] = 0;
            end
            m_exp[c] = nxt(m_exp[c]);
            if (m_miss[c] == unl[c]) begin
              m_lock[c] = 0; m_match[c] = 0; m_have[c] = 0; m_miss[c] = 0;
            end
          end
        end
        if (i_clr_err) m_cnt[c] = 0;
      end
    end
  end

  always @(negedge clk) begin
    if (i_rst) begin
      check("a_lock", int'(lock_a), m_lock[0]);
      check("a_error", int'(error_a), m_err[0]);
      check("a_count", int'(cnt_a), m_cnt[0]);
      check("a_expected", int'(exp_a), int'(m_exp[0]));
      check("b_lock", int'(lock_b), m_lock[1]);
      check("b_error", int'(error_b), m_err[1]);
      check("b_count", int'(cnt_b), m_cnt[1]);
      check("b_expected", int'(exp_b), int'(m_exp[1]));
    end
  end

  task automatic send(input logic [7:0] v, input logic clr = 1'b0);
    @(negedge clk);
    i_valid = 1'b1; i_lfsr = v; i_clr_err = clr;
    @(posedge clk);
    #1;
    i_valid = 1'b0; i_clr_err = 1'b0;
  endtask

  task automatic soft_reset(input logic [7:0] v);
    @(negedge clk);
    i_soft_reset = 1'b1; i_valid = 1'b1; i_lfsr = v;
    @(posedge clk);
    #1;
    i_soft_reset = 1'b0; i_valid = 1'b0;
  endtask

  logic [7:0] seq1[5] = '{8'hFF, 8'hFE, 8'hFC, 8'hF8, 8'hF0};
  logic [7:0] wrong;

  initial begin
    repeat (2) @(negedge clk);
    check("reset_lock", int'(lock_a), 0);
    check("reset_expected", int'(exp_a), 0);
    check("reset_count", int'(cnt_a), 0);
    i_rst = 1'b1;

    // 1. lock-in
    for (int i = 0; i < 5; i++) begin
      send(seq1[i]);
      if (i == 3) check("lock_before_5th", int'(lock_a), 0);
    end
    check("t1_lock", int'(lock_a), 1);
    check("t1_expected", int'(exp_a), 32'hE1);
    check("t1_count", int'(cnt_a), 0);

    // 2. single error
    send(8'hE0);
    check("t2_error_pulse", int'(error_a), 1);
    check("t2_count", int'(cnt_a), 1);
    check("t2_expected", int'(exp_a), 32'hC2);
    send(8'hC2);
    check("t2_no_error", int'(error_a), 0);
    check("t2_lock", int'(lock_a), 1);
    check("t2_expected2", int'(exp_a), 32'h85);

    // 3. loss of lock, then relock
    repeat (3) send(8'h55);
    check("t3_count", int'(cnt_a), 4);
    check("t3_unlock", int'(lock_a), 0);
    check("t3_b_still_locked", int'(lock_b), 1);
    for (int i = 0; i < 5; i++) send(seq1[i]);
    check("t3_relock", int'(lock_a), 1);
    check("t3_count_held", int'(cnt_a), 4);

    // 4. gapped valid
    soft_reset(8'h12);
    for (int i = 0; i < 5; i++) begin
      repeat ($urandom_range(0, 3)) @(negedge clk);
      send(seq1[i]);
      if (i == 3) check("t4_lock_before_5th", int'(lock_a), 0);
    end
    check("t4_lock", int'(lock_a), 1);
    check("t4_expected", int'(exp_a), 32'hE1);
    check("t4_count", int'(cnt_a), 0);

    // 5. saturation on dut_b; one correct sample splits the run to keep it locked
    for (int i = 0; i < 21; i++) begin
      wrong = (m_exp[1] == 8'hFF) ? 8'h55 : ~m_exp[1];
      send((i == 10) ? m_exp[1] : wrong);
    end
    check("t5_saturated", int'(cnt_b), 15);
    check("t5_b_lock", int'(lock_b), 1);
    wrong = (m_exp[1] == 8'hFF) ? 8'h55 : ~m_exp[1];
    send(wrong, 1'b1);
    check("t5_clear_wins", int'(cnt_b), 0);
    check("t5_error_on_clear", int'(error_b), 1);

    // 6. soft reset while locked, sample dropped
    soft_reset(m_exp[1]);
    check("t6_soft_lock", int'(lock_b), 0);
    check("t6_soft_expected", int'(exp_b), 0);
    check("t6_soft_error", int'(error_b), 0);
    check("t6_soft_count_a", int'(cnt_a), 0);
    send(8'hFE);
    check("t6_first_after_soft", int'(exp_a), 32'hFC);
    check("t6_lock_after_soft", int'(lock_a), 0);
    send(8'hFC);
    @(posedge clk);
    #2;
    i_rst = 1'b0;
    #1;
    check("t6_async_expected", int'(exp_a), 0);
    check("t6_async_lock", int'(lock_a), 0);
    repeat (2) @(negedge clk);
    i_rst = 1'b1;
    for (int i = 0; i < 5; i++) send(seq1[i]);
    check("t6_relock_after_rst", int'(lock_a), 1);
    repeat (2) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/lfsr_checker.md
Name: lfsr_checker

Overview:
Downstream consumer of the 8-bit LFSR_generator output. It samples o_LFSR on each valid strobe and self-synchronises to the sequence by predicting each next value from the previous one. Once locked, it flags every mismatching sample and counts mismatches in a saturating error counter. It is the receive-side checker for PRBS loopback and BER tests.

Parameters:
TAPS, 8'hB8, feedback mask; next(x) = {x[6:0], ^(x & TAPS)}. This must match the generator polynomial x^8+x^6+x^5+x^4+1.
LOCK_CNT, 4, number of consecutive correct predictions required to enter LOCKED (range 1..15).
UNLOCK_CNT, 3, number of consecutive mismatches in LOCKED that force UNLOCKED (range 1..15).
ERR_W, 16, width of the error counter.

Ports:
clk  in  1  system clock, rising edge
i_rst  in  1  asynchronous, active-low reset
i_soft_reset  in  1  synchronous clear, active-high
i_valid  in  1  sample strobe; one sample is taken per cycle in which i_valid=1
i_lfsr  in  8  LFSR sample (driven from the generator's o_LFSR)
i_clr_err  in  1  synchronous clear of o_err_count
o_lock  out  1  registered; 1 while in LOCKED
o_error  out  1  one-cycle pulse on a mismatch while LOCKED
o_err_count  out  ERR_W  saturating mismatch count
o_expected  out  8  value predicted for the next sample (debug)

Behaviour:
- Reset (i_rst=0, asynchronous): state UNLOCKED, have_prev=0, match_cnt=0, miss_cnt=0, o_lock=0, o_error=0, o_err_count=0, o_expected=8'h00.
- i_soft_reset=1 at a clock edge: same values as reset. It overrides i_valid and i_clr_err in that cycle, and the sample is dropped.
- All outputs are registered. Results for a sample taken at edge N are visible after edge N.
- Cycles with i_valid=0 change nothing (o_error is forced to 0).
- UNLOCKED state, on a valid sample:
  - If have_prev=0: set have_prev=1 and load o_expected=next(i_lfsr). No compare is made.
  - Otherwise, if i_lfsr==o_expected: match_cnt++.
  - Otherwise: match_cnt=0.
  - In both compare cases, o_expected=next(i_lfsr).
  - When match_cnt reaches LOCK_CNT: go to LOCKED, o_lock=1, miss_cnt=0.
  - o_error stays 0 and the error count never changes in UNLOCKED.
- LOCKED state, on a valid sample:
  - o_expected=next(o_expected). The predictor free-runs and is never reloaded from the input.
  - Mismatch: o_error=1 for one cycle, o_err_count++ (saturates at all-ones and holds), miss_cnt++.
  - Match: miss_cnt=0.
  - When miss_cnt reaches UNLOCK_CNT: go to UNLOCKED, o_lock=0, match_cnt=0, have_prev=0.
- i_clr_err=1: o_err_count=0. If a mismatch occurs in the same cycle, the clear wins (count=0), but o_error still pulses.
- An all-zero sample is treated as ordinary data, unless the optional feature below is compiled in.

Optional Feature:
Macro LFSR_CHECKER_ZERO_DET_EN.
- Defined:
  - A valid sample equal to 8'h00 sets a sticky output o_zero_lock (extra 1-bit port, reset 0, cleared by i_soft_reset).
  - In UNLOCKED, such a sample forces match_cnt=0 and have_prev=0.
  - In LOCKED, it counts as a mismatch.
- Not defined: the o_zero_lock port is absent and 8'h00 gets no special handling.

Test Plan:
1. Lock-in: release i_rst, then feed FF,FE,FC,F8,F0 with i_valid=1 -> o_lock=1 after the F0 edge, o_expected=E1, o_err_count=0.
2. Single error: while locked, feed E0 then C2 -> o_error pulses once (on E0), o_err_count=1, o_lock stays 1, no error on C2.
3. Loss of lock: while locked, feed three samples of 8'h55 -> o_err_count +3, o_lock=0 after the third; re-feeding a correct 5-sample run relocks.
4. Gapped valid: the test-1 sequence with random i_valid=0 gaps between samples -> identical lock timing in valid-sample count, no o_error.
5. Saturation and clear: ERR_W=4; 20 mismatches with UNLOCK_CNT=15 -> o_err_count holds at 15; i_clr_err=1 in the same cycle as a mismatch -> count 0 and o_error=1.
6. Resets: i_soft_reset=1 together with i_valid=1 while locked -> all outputs return to their reset values and the sample is ignored; i_rst asserted mid-stream between clock edges -> outputs clear immediately.
